// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC-source sequencer: FSM states,
// decoded instruction classes, PC mux select codes and default vectors.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_EXC_SAVE = 3'd3,
        ST_EXC_RD   = 3'd4,
        ST_EXC_LD   = 3'd5,
        ST_HALT     = 3'd6
    } state_t;

    // Decoded instruction classes; anything above CLS_RTE is illegal.
    localparam logic [2:0] CLS_SEQ    = 3'b000;
    localparam logic [2:0] CLS_BRANCH = 3'b001;
    localparam logic [2:0] CLS_JUMP   = 3'b010;
    localparam logic [2:0] CLS_JR     = 3'b011;
    localparam logic [2:0] CLS_RTE    = 3'b100;

    // PC mux select codes.
    localparam logic [2:0] PCSRC_SEQ    = 3'b000;
    localparam logic [2:0] PCSRC_EPC    = 3'b001;
    localparam logic [2:0] PCSRC_ALUOUT = 3'b010;
    localparam logic [2:0] PCSRC_JUMP   = 3'b011;
    localparam logic [2:0] PCSRC_MDR    = 3'b100;

    // Default exception vector addresses.
    localparam logic [7:0] VEC_ILLEGAL_DEF = 8'd253;
    localparam logic [7:0] VEC_OVF_DEF     = 8'd254;
    localparam logic [7:0] VEC_DIVZ_DEF    = 8'd255;

    function automatic logic cls_illegal(input logic [2:0] cls);
        return cls > CLS_RTE;
    endfunction

    // Next-PC source for an instruction that commits without an exception.
    function automatic logic [2:0] commit_src(input logic [2:0] cls, input logic taken);
        case (cls)
            CLS_BRANCH: return taken ? PCSRC_ALUOUT : PCSRC_SEQ;
            CLS_JUMP:   return PCSRC_JUMP;
            CLS_JR:     return PCSRC_ALUOUT;
            CLS_RTE:    return PCSRC_EPC;
            default:    return PCSRC_SEQ;
        endcase
    endfunction

endpackage

// File: rtl/pc_seq_watchdog.sv
// Vector-fetch watchdog. Counts cycles spent waiting for mem_ready and
// flags expiry on the WD_LIMIT-th waiting cycle unless ready arrives in
// that same cycle. Only instantiated when PC_SEQ_WATCHDOG_EN is defined.
module pc_seq_watchdog #(
    parameter int unsigned WD_LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expire
);

    localparam int unsigned CW = $clog2(WD_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(WD_LIMIT - 1);

    logic [CW-1:0] count;

    // Wait-cycle counter: cleared just before the fetch starts, advances each fetch cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    // The edge ending this cycle would bring the count to WD_LIMIT with no data.
    assign expire = count_en && !ready && (count == LAST);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Control-flow sequencer for the PC source mux. Resolves the next-PC source
// of one decoded instruction at a time and sequences exception entry
// (EPC save, vector fetch, PC load from MDR). All outputs are registered.
// Optional feature: define PC_SEQ_WATCHDOG_EN to bound the vector fetch
// with a watchdog that parks the sequencer in HALT and raises fault.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int unsigned WD_LIMIT    = 16,
    parameter logic [7:0]  VEC_ILLEGAL = VEC_ILLEGAL_DEF,
    parameter logic [7:0]  VEC_OVF     = VEC_OVF_DEF,
    parameter logic [7:0]  VEC_DIVZ    = VEC_DIVZ_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [2:0] instr_class,
    input  logic       branch_cond,
    input  logic       ovf,
    input  logic       div_zero,
    input  logic       mem_ready,
    output logic [2:0] pc_src,
    output logic       pc_write,
    output logic       epc_write,
    output logic       mem_rd,
    output logic [7:0] vec_addr,
    output logic       busy,
    output logic       instr_done,
    output logic       fault
);

    state_t     state;
    logic [2:0] cls_q;
    logic [7:0] vec_q;

    if (WD_LIMIT == 0) begin : g_bad_wd_limit
        $error("pc_seq_ctrl: WD_LIMIT must be nonzero");
    end

`ifdef PC_SEQ_WATCHDOG_EN
    logic fault_q;
    logic wd_expire;

    pc_seq_watchdog #(
        .WD_LIMIT (WD_LIMIT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (state == ST_EXC_SAVE),
        .count_en (state == ST_EXC_RD),
        .ready    (mem_ready),
        .expire   (wd_expire)
    );

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Sequencer FSM; outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cls_q      <= CLS_SEQ;
            vec_q      <= '0;
            pc_src     <= PCSRC_SEQ;
            pc_write   <= 1'b0;
            epc_write  <= 1'b0;
            mem_rd     <= 1'b0;
            vec_addr   <= '0;
            busy       <= 1'b0;
            instr_done <= 1'b0;
`ifdef PC_SEQ_WATCHDOG_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            // Strobes default low; only the entered state raises them.
            pc_src     <= PCSRC_SEQ;
            pc_write   <= 1'b0;
            epc_write  <= 1'b0;
            mem_rd     <= 1'b0;
            vec_addr   <= '0;
            instr_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        cls_q <= instr_class;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    // Illegal class outranks overflow, which outranks divide-by-zero.
                    if (cls_illegal(cls_q) || ovf || div_zero) begin
                        if (cls_illegal(cls_q)) begin
                            vec_q <= VEC_ILLEGAL;
                        end else if (ovf) begin
                            vec_q <= VEC_OVF;
                        end else begin
                            vec_q <= VEC_DIVZ;
                        end
                        epc_write <= 1'b1;
                        state     <= ST_EXC_SAVE;
                    end else begin
                        // The registered select doubles as the sampled branch outcome.
                        pc_src     <= commit_src(cls_q, branch_cond);
                        pc_write   <= 1'b1;
                        instr_done <= 1'b1;
                        state      <= ST_COMMIT;
                    end
                end

                ST_COMMIT, ST_EXC_LD: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                ST_EXC_SAVE: begin
                    mem_rd   <= 1'b1;
                    vec_addr <= vec_q;
                    state    <= ST_EXC_RD;
                end

                ST_EXC_RD: begin
                    if (mem_ready) begin
                        pc_src     <= PCSRC_MDR;
                        pc_write   <= 1'b1;
                        instr_done <= 1'b1;
                        state      <= ST_EXC_LD;
                    end
`ifdef PC_SEQ_WATCHDOG_EN
                    else if (wd_expire) begin
                        fault_q <= 1'b1;
                        state   <= ST_HALT;
                    end
`endif
                    else begin
                        mem_rd   <= 1'b1;
                        vec_addr <= vec_q;
                    end
                end

                // Only reset leaves HALT.
                ST_HALT: begin
                    state <= ST_HALT;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl. Each directed instruction is turned
// into an expected per-cycle output schedule from the timing rules; a single
// negedge process compares every cycle against that schedule, and a set of
// literal checks at the end pins key values.
`timescale 1ns/1ps
module tb_pc_seq_ctrl;

    localparam int WD_LIMIT = 16;
    localparam int MAXC     = 512;

`ifdef PC_SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] pc_src;
        logic       pc_write;
        logic       epc_write;
        logic       mem_rd;
        logic [7:0] vec_addr;
        logic       busy;
        logic       instr_done;
        logic       fault;
    } outs_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [2:0] instr_class;
    logic       branch_cond;
    logic       ovf;
    logic       div_zero;
    logic       mem_ready;
    logic [2:0] pc_src;
    logic       pc_write;
    logic       epc_write;
    logic       mem_rd;
    logic [7:0] vec_addr;
    logic       busy;
    logic       instr_done;
    logic       fault;

    pc_seq_ctrl #(
        .WD_LIMIT    (WD_LIMIT),
        .VEC_ILLEGAL (8'd253),
        .VEC_OVF     (8'd254),
        .VEC_DIVZ    (8'd255)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_class (instr_class),
        .branch_cond (branch_cond),
        .ovf         (ovf),
        .div_zero    (div_zero),
        .mem_ready   (mem_ready),
        .pc_src      (pc_src),
        .pc_write    (pc_write),
        .epc_write   (epc_write),
        .mem_rd      (mem_rd),
        .vec_addr    (vec_addr),
        .busy        (busy),
        .instr_done  (instr_done),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;
    bit    cmp_en   = 1'b0;
    outs_t exp_tab [MAXC];
    outs_t got_tab [MAXC];
    outs_t g;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic outs_t mk(input logic [2:0] src, input logic pw, input logic ew,
                                 input logic rd, input logic [7:0] va, input logic bz,
                                 input logic dn, input logic ft);
        outs_t o;
        o.pc_src     = src;
        o.pc_write   = pw;
        o.epc_write  = ew;
        o.mem_rd     = rd;
        o.vec_addr   = va;
        o.busy       = bz;
        o.instr_done = dn;
        o.fault      = ft;
        return o;
    endfunction

    // Per-cycle comparison against the expected schedule.
    always @(negedge clock) begin
        g = mk(pc_src, pc_write, epc_write, mem_rd, vec_addr, busy, instr_done, fault);
        if (cyc < MAXC) begin
            got_tab[cyc] = g;
            if (cmp_en) begin
                checks++;
                if (g !== exp_tab[cyc]) begin
                    failures++;
                    $display("FAIL cycle%0d outputs: got src=%0d pw=%b ew=%b rd=%b va=%0d busy=%b done=%b fault=%b, want src=%0d pw=%b ew=%b rd=%b va=%0d busy=%b done=%b fault=%b",
                             cyc, g.pc_src, g.pc_write, g.epc_write, g.mem_rd, g.vec_addr, g.busy, g.instr_done, g.fault,
                             exp_tab[cyc].pc_src, exp_tab[cyc].pc_write, exp_tab[cyc].epc_write, exp_tab[cyc].mem_rd,
                             exp_tab[cyc].vec_addr, exp_tab[cyc].busy, exp_tab[cyc].instr_done, exp_tab[cyc].fault);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input int idx, input outs_t o);
        if (idx >= 0 && idx < MAXC) exp_tab[idx] = o;
    endtask

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic logic [7:0] vec_of(input logic [2:0] cls, input logic ov);
        if (cls > 3'd4) return 8'd253;
        if (ov) return 8'd254;
        return 8'd255;
    endfunction

    // One instruction: schedule its outputs, then drive it. With noise set,
    // inputs the sequencer must ignore are toggled while it is busy.
    task automatic issue(input logic [2:0] cls, input logic bc, input logic ov, input logic dz,
                         input int rdy_dly, input bit noise);
        int         c;
        int         m;
        bit         exc;
        logic [7:0] v;
        logic [2:0] src;
        c   = cyc;
        exc = (cls > 3'd4) || ov || dz;
        v   = vec_of(cls, ov);
        case (cls)
            3'd1:    src = bc ? 3'b010 : 3'b000;
            3'd2:    src = 3'b011;
            3'd3:    src = 3'b010;
            3'd4:    src = 3'b001;
            default: src = 3'b000;
        endcase
        m = c + 3 + rdy_dly;
        put(c + 1, mk(3'b000, 0, 0, 0, 8'd0, 1, 0, 0));
        if (!exc) begin
            put(c + 2, mk(src, 1, 0, 0, 8'd0, 1, 1, 0));
        end else begin
            put(c + 2, mk(3'b000, 0, 1, 0, 8'd0, 1, 0, 0));
            for (int k = c + 3; k <= m; k++) put(k, mk(3'b000, 0, 0, 1, v, 1, 0, 0));
            put(m + 1, mk(3'b100, 1, 0, 0, 8'd0, 1, 1, 0));
        end

        instr_valid = 1'b1; instr_class = cls;
        mem_ready = noise; ovf = noise; div_zero = noise;
        step();
        instr_valid = noise; instr_class = 3'b111;
        branch_cond = bc; ovf = ov; div_zero = dz; mem_ready = noise;
        step();
        instr_valid = noise; branch_cond = noise; ovf = noise; div_zero = noise; mem_ready = noise;
        step();
        instr_valid = 1'b0; branch_cond = 1'b0; ovf = 1'b0; div_zero = 1'b0; mem_ready = 1'b0;
        if (exc) begin
            for (int k = c + 3; k <= m; k++) begin
                instr_valid = noise; ovf = noise;
                mem_ready = (k == m);
                step();
            end
            instr_valid = noise; mem_ready = noise;
            step();
            instr_valid = 1'b0; mem_ready = 1'b0; ovf = 1'b0;
        end
    endtask

    // Exception whose vector never arrives; reset is pulsed after 'hold'
    // fetch-wait cycles. Returns the cycle in which reset was driven low.
    task automatic issue_stall(input logic [2:0] cls, input logic ov, input logic dz,
                               input int hold, output int r);
        int         c;
        logic [7:0] v;
        c = cyc;
        v = vec_of(cls, ov);
        r = c + 3 + hold;
        put(c + 1, mk(3'b000, 0, 0, 0, 8'd0, 1, 0, 0));
        put(c + 2, mk(3'b000, 0, 1, 0, 8'd0, 1, 0, 0));
        for (int k = c + 3; k <= r; k++) begin
            if (WD_ON && (k >= c + 3 + WD_LIMIT)) put(k, mk(3'b000, 0, 0, 0, 8'd0, 1, 0, 1));
            else put(k, mk(3'b000, 0, 0, 1, v, 1, 0, 0));
        end
        for (int k = r + 1; k < MAXC; k++) put(k, '0);

        instr_valid = 1'b1; instr_class = cls;
        step();
        instr_valid = 1'b0; ovf = ov; div_zero = dz;
        step();
        ovf = 1'b0; div_zero = 1'b0;
        step();
        repeat (hold) begin
            instr_valid = 1'b1;
            step();
        end
        instr_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    int t_rst, t_seq, t_bt, t_bn, t_j, t_jr, t_rte, t_ill, t_both, t_dz, t_rtex;
    int t_ab, r_ab, t_post, t_hang, r_hang, t_after, n_done;

    initial begin
        reset = 1'b0; instr_valid = 1'b0; instr_class = 3'b000; branch_cond = 1'b0;
        ovf = 1'b0; div_zero = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < MAXC; i++) exp_tab[i] = '0;
        repeat (3) step();
        cmp_en = 1'b1;
        t_rst  = cyc;
        reset  = 1'b1;
        step();
        step();

        t_seq  = cyc; issue(3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        t_bt   = cyc; issue(3'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        t_bn   = cyc; issue(3'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        t_j    = cyc; issue(3'd2, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        t_jr   = cyc; issue(3'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        t_rte  = cyc; issue(3'd4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step();
        t_ill  = cyc; issue(3'b111, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        t_both = cyc; issue(3'd0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        t_dz   = cyc; issue(3'd2, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        t_rtex = cyc; issue(3'd4, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        t_ab   = cyc; issue_stall(3'b101, 1'b0, 1'b0, 2, r_ab);
        step();
        t_post = cyc; issue(3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        t_hang = cyc; issue_stall(3'd2, 1'b0, 1'b1, 24, r_hang);
        t_after = cyc; issue(3'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) step();
        cmp_en = 1'b0;

        chk("reset_state", int'(got_tab[t_rst]), 0);
        chk("seq_pc_write_c3", int'(got_tab[t_seq + 2].pc_write), 1);
        chk("seq_pc_src_c3", int'(got_tab[t_seq + 2].pc_src), 0);
        chk("seq_pc_write_c2", int'(got_tab[t_seq + 1].pc_write), 0);
        chk("seq_done_c3", int'(got_tab[t_seq + 2].instr_done), 1);
        chk("seq_busy_c4", int'(got_tab[t_seq + 3].busy), 0);
        chk("branch_taken_src", int'(got_tab[t_bt + 2].pc_src), 2);
        chk("branch_not_taken_src", int'(got_tab[t_bn + 2].pc_src), 0);
        chk("branch_not_taken_pw", int'(got_tab[t_bn + 2].pc_write), 1);
        chk("jump_src", int'(got_tab[t_j + 2].pc_src), 3);
        chk("jr_src", int'(got_tab[t_jr + 2].pc_src), 2);
        chk("rte_src", int'(got_tab[t_rte + 2].pc_src), 1);
        chk("illegal_epc_write", int'(got_tab[t_ill + 2].epc_write), 1);
        chk("illegal_vec", int'(got_tab[t_ill + 3].vec_addr), 253);
        chk("illegal_ld_src", int'(got_tab[t_ill + 7].pc_src), 4);
        chk("illegal_ld_pw", int'(got_tab[t_ill + 7].pc_write), 1);
        chk("ovf_divz_vec", int'(got_tab[t_both + 3].vec_addr), 254);
        chk("min_latency_pw", int'(got_tab[t_both + 4].pc_write), 1);
        chk("divz_vec", int'(got_tab[t_dz + 3].vec_addr), 255);
        chk("rte_flag_epc_write", int'(got_tab[t_rtex + 2].epc_write), 1);
        chk("abort_pre_mem_rd", int'(got_tab[r_ab].mem_rd), 1);
        chk("abort_post_outputs", int'(got_tab[r_ab + 1]), 0);
        chk("post_abort_pw", int'(got_tab[t_post + 2].pc_write), 1);
        chk("hang_c18_mem_rd", int'(got_tab[t_hang + 18].mem_rd), 1);
        chk("hang_c19_fault", int'(got_tab[t_hang + 19].fault), WD_ON ? 1 : 0);
        chk("hang_c19_mem_rd", int'(got_tab[t_hang + 19].mem_rd), WD_ON ? 0 : 1);
        chk("hang_end_pw", int'(got_tab[r_hang].pc_write), 0);
        chk("hang_reset_fault", int'(got_tab[r_hang + 1].fault), 0);
        chk("after_hang_jr_src", int'(got_tab[t_after + 2].pc_src), 2);

        n_done = 0;
        for (int i = t_rst; i < cyc && i < MAXC; i++) n_done += int'(got_tab[i].instr_done);
        chk("instr_done_pulses", n_done, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Control-flow sequencer that drives the select and write-enable of the program-counter source multiplexer. It accepts one decoded instruction at a time and resolves its next-PC source: sequential, branch target in ALUOut, jump target, or EPC for return-from-exception. On an exception it sequences EPC capture, the vector fetch from memory, and the PC load from MDR. It sits between instruction decode and the datapath PC/EPC registers.

## Interface
Parameters:
- WD_LIMIT, 16: cycles allowed for `mem_ready` during a vector fetch. Used only with the watchdog.
- VEC_ILLEGAL, 8'd253: vector memory address for an illegal class.
- VEC_OVF, 8'd254: vector memory address for arithmetic overflow.
- VEC_DIVZ, 8'd255: vector memory address for divide-by-zero.

Ports:
- `clock`, in, 1: single clock; everything is rising-edge.
- `reset`, in, 1: synchronous, active-low.
- `instr_valid`, in, 1: decode info valid. Accepted only in IDLE.
- `instr_class`, in, 3: 000 seq, 001 branch, 010 jump, 011 jr, 100 rte; 101–111 are illegal.
- `branch_cond`, in, 1: branch taken.
- `ovf`, in, 1: arithmetic overflow.
- `div_zero`, in, 1: divide by zero.
- `mem_ready`, in, 1: vector read data is valid in MDR.
- `pc_src`, out, 3: PC mux select. 000 seq adder, 001 EPC, 010 ALUOut, 011 jump, 100 MDR.
- `pc_write`, out, 1: PC load enable.
- `epc_write`, out, 1: EPC load enable.
- `mem_rd`, out, 1: vector read request.
- `vec_addr`, out, 8: vector memory address.
- `busy`, out, 1: high in every state except IDLE.
- `instr_done`, out, 1: one-cycle pulse when the instruction completes.
- `fault`, out, 1: sticky watchdog fault.

## Operation
- States: IDLE, EXEC, COMMIT, EXC_SAVE, EXC_RD, EXC_LD, HALT.
- **IDLE**
  - `instr_valid` high: latch `instr_class`, go to EXEC.
  - `instr_valid` low: stay in IDLE.
- **EXEC**
  - Sample `branch_cond`, `ovf` and `div_zero` into registers.
  - Exception priority: illegal class > `ovf` > `div_zero`.
  - Any exception: latch the matching vector, go to EXC_SAVE.
  - No exception: go to COMMIT.
- **COMMIT**
  - `pc_write`=1, `instr_done`=1.
  - `pc_src` by class:
    - seq: 000
    - branch taken: 010; branch not taken: 000
    - jump: 011
    - jr: 010
    - rte: 001
  - Next state: IDLE.
- **EXC_SAVE**
  - `epc_write`=1; next state EXC_RD.
- **EXC_RD**
  - `mem_rd`=1 and `vec_addr` valid, held until `mem_ready` is sampled high.
  - `mem_ready` high: go to EXC_LD.
- **EXC_LD**
  - `pc_src`=100, `pc_write`=1, `instr_done`=1; next state IDLE.
- **HALT**
  - Reached only via the watchdog; left only by reset.
- All outputs are Moore, decoded from state and latched registers. In states that do not write the PC, `pc_src`=000.
- Boundary rules:
  - `instr_valid` while busy: ignored, not queued.
  - `mem_ready` outside EXC_RD: ignored.
  - Exception flags outside EXEC: ignored.
  - `ovf` and `div_zero` together: `vec_addr`=VEC_OVF.
  - rte with a flag raised: the exception is taken; EPC is overwritten.
  - Reset in any state: next cycle is IDLE, outputs at reset values, pending `mem_rd` dropped, `fault` cleared.

## Timing
- Reset values: `pc_src`=000; all 1-bit outputs 0; `vec_addr`=0; state IDLE.
- Normal instruction: `instr_valid` at edge N gives EXEC in N+1 and COMMIT in N+2. `pc_write` and `instr_done` are high for exactly one cycle. Earliest next accept is N+3.
- Exception path:
  - EXEC in N+1, EPC write in N+2.
  - `mem_rd` from N+3.
  - `mem_ready` sampled at cycle M gives EXC_LD in M+1.
  - Minimum latency: `pc_write` in N+4 if `mem_ready` is high in N+3.
- `epc_write` and `pc_write` are never high in the same cycle.

## Configuration
- `PC_SEQ_WATCHDOG_EN` defined:
  - A counter clears on entry to EXC_RD and increments each EXC_RD cycle.
  - The watchdog fires when the counter reaches WD_LIMIT without `mem_ready`.
  - On firing: go to HALT, `fault`=1, `busy`=1, `mem_rd`=0, no PC write.
  - `mem_ready` in the same cycle the counter reaches WD_LIMIT wins: go to EXC_LD.
- `PC_SEQ_WATCHDOG_EN` undefined:
  - EXC_RD waits indefinitely.
  - HALT is unreachable; `fault` is tied 0; no counter logic.

## Structure
- Package `pc_seq_pkg` holds:
  - state enum;
  - class codes;
  - `pc_src` codes PCSRC_SEQ/EPC/ALUOUT/JUMP/MDR (000–100);
  - default vector constants.
- Sub-module `pc_seq_watchdog`:
  - inputs: clear, count-enable, ready;
  - output: expire;
  - instantiated only under `PC_SEQ_WATCHDOG_EN`.

## Test plan
- Seq class, no flags, `instr_valid` at cycle 1: `pc_src`=000 and `pc_write`=1 at cycle 3 only; `instr_done` pulse at cycle 3; `busy` low at cycle 4.
- Branch with `branch_cond`=1, then branch with `branch_cond`=0: `pc_src`=010, then `pc_src`=000 in the respective COMMIT cycles. Jump gives 011; rte gives 001.
- Class 111 with `ovf`=1: `epc_write` pulse, `mem_rd` with `vec_addr`=253. `mem_ready` after 3 cycles: EXC_LD with `pc_src`=100 and `pc_write`=1.
- `ovf` and `div_zero` both high: `vec_addr`=254. A second `instr_valid` while busy is ignored, with no extra `instr_done`.
- Reset low during EXC_RD: next cycle all outputs are 0 and state is IDLE. A new seq instruction then completes normally.
- With `PC_SEQ_WATCHDOG_EN` and WD_LIMIT=16, `mem_ready` held low: HALT after 16 EXC_RD cycles, `fault`=1, `pc_write` never asserted. Reset clears `fault`.
